ref_window_fetch: RTL and testbench

- Producer end of the reference-pixel word stream consumed by the reference search-window SRAM.
- On each window request, reads one motion-estimation search window from frame memory and streams it as 64-bit words (8 pixels, little-endian byte order) under the consumer's read_en handshake.
- Sits between the frame-memory read port and the reference SRAM.
- Owns address generation, memory-latency hiding and flow control.

---
 rtl/ref_window_fetch_pkg.sv | 19 +
 rtl/ref_word_fifo.sv | 51 +++++
 rtl/ref_window_fetch.sv | 115 +++++++++++
 tb/tb_ref_window_fetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ref_window_fetch_pkg.sv
// Shared search-window geometry and fetch FSM encoding, used by the window
// fetcher and the reference SRAM so both agree on window shape.
package ref_window_fetch_pkg;

    localparam int FRAME_W   = 352;
    localparam int WIN_WORDS = 3;
    localparam int WIN_ROWS  = 23;
    localparam int PIX_W     = 8;
    localparam int WORD_PIX  = 8;
    localparam int WIN_TOTAL = WIN_WORDS * WIN_ROWS;
    localparam int WORD_BITS = PIX_W * WORD_PIX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ref_word_fifo.sv
// Two-entry word FIFO with a combinational head; absorbs the one-cycle
// frame-memory read latency so the stream can run at one word per cycle.
module ref_word_fifo
    import ref_window_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WORD_BITS-1:0] data,
    input  logic                 pop,
    output logic [WORD_BITS-1:0] head,
    output logic                 valid,
    output logic [1:0]           count
);

    logic [WORD_BITS-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign valid   = (count != 2'd0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && valid;
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is cleared so the head reads zero out of reset instead of X.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ref_window_fetch.sv
// Reads one search window from frame memory in row-major order and streams it
// to the reference SRAM under the consumer's read_en handshake.
module ref_window_fetch
    import ref_window_fetch_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    win_base,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [WORD_BITS-1:0] mem_rdata,
    output logic [WORD_BITS-1:0] ref_in,
    output logic                 ref_valid,
    input  logic                 read_en,
    output logic                 busy,
    output logic                 done
);

    localparam int WORD_W = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1;
    localparam int ROW_W  = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
    localparam int CNT_W  = $clog2(WIN_TOTAL + 1);

    fetch_state_e      state;
    logic [ADDR_W-1:0] row_base;
    logic [WORD_W-1:0] word_idx;
    logic [ROW_W-1:0]  row_idx;
    logic [CNT_W-1:0]  xfer_cnt;
    logic              rd_pend;
    logic [1:0]        fifo_count;
    logic              xfer;
    logic [2:0]        occ_after;
    logic              last_word;
    logic              last_row;

    assign xfer      = ref_valid && read_en;
    assign last_word = (word_idx == WORD_W'(WIN_WORDS - 1));
    assign last_row  = (row_idx == ROW_W'(WIN_ROWS - 1));

    // NOTE: mem_rd depends on this cycle's pop so a freed slot is reused at once;
    // registering it would add a cycle to the credit loop and cap throughput at 2/3.
    assign occ_after = {1'b0, fifo_count} + {2'b00, rd_pend} - {2'b00, xfer};
    assign mem_rd    = (state == ST_FETCH) && (occ_after < 3'd2);

    ref_word_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend),
        .data  (mem_rdata),
        .pop   (read_en),
        .head  (ref_in),
        .valid (ref_valid),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            row_base <= '0;
            word_idx <= '0;
            row_idx  <= '0;
            xfer_cnt <= '0;
            rd_pend  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_pend <= mem_rd;
            done    <= 1'b0;
            if (xfer) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        mem_addr <= win_base;
                        row_base <= win_base;
                        word_idx <= '0;
                        row_idx  <= '0;
                        xfer_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem_rd) begin
                        if (last_word) begin
                            word_idx <= '0;
                            row_idx  <= row_idx + ROW_W'(1);
                            row_base <= row_base + ADDR_W'(FRAME_W);
                            mem_addr <= row_base + ADDR_W'(FRAME_W);
                            if (last_row) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            word_idx <= word_idx + WORD_W'(1);
                            mem_addr <= mem_addr + ADDR_W'(8);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer && (xfer_cnt == CNT_W'(WIN_TOTAL - 1))) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ref_window_fetch.sv
// Self-checking bench for ref_window_fetch: directed vector table plus
// randomized runs compared against an address/pixel model of the window.
module tb_ref_window_fetch;

    localparam int ADDR_W = 17;
    localparam int N_WORDS = 69;

    typedef enum int {PAT_ALWAYS, PAT_TOGGLE, PAT_STALL, PAT_RANDOM} pat_e;

    typedef struct {
        logic [ADDR_W-1:0] base;
        pat_e              pat;
        bit                poke;
        bit                abort;
        logic [63:0]       first;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] win_base;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_rdata;
    logic [63:0]       ref_in;
    logic              ref_valid;
    logic              read_en;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    ref_window_fetch #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .win_base  (win_base),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .ref_in    (ref_in),
        .ref_valid (ref_valid),
        .read_en   (read_en),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel at byte address a has value a[7:0].
    function automatic logic [63:0] word_at(input logic [ADDR_W-1:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            w[8*i +: 8] = 8'((int'(a) + i) % 256);
        end
        return w;
    endfunction

    // Address of the k-th word of the window, row-major, modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] base, input int k);
        int r;
        int w;
        r = k / 3;
        w = k % 3;
        return ADDR_W'(int'(base) + r * 352 + w * 8);
    endfunction

    // Frame memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= word_at(mem_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pick(input pat_e p, input int cyc);
        int m;
        m = (cyc - 1) % 4;
        case (p)
            PAT_ALWAYS: return 1'b1;
            PAT_TOGGLE: return (m == 0) || (m == 3);
            PAT_STALL:  return cyc > 20;
            default:    return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic run_vec(input vec_t v);
        int          cyc;
        int          issue_n;
        int          xfer_n;
        int          last_xfer;
        logic        prev_hold;
        logic [63:0] prev_word;
        logic        saw_done;
        bit          fin;
        @(posedge clk);
        #1;
        start    = 1'b1;
        win_base = v.base;
        read_en  = 1'b0;
        cyc = 0; issue_n = 0; xfer_n = 0; last_xfer = -10;
        prev_hold = 1'b0; prev_word = '0; fin = 0;
        while (!fin) begin
            @(posedge clk);
            #1;
            cyc++;
            start = v.poke && (cyc == 10);
            if (v.poke && cyc == 10) win_base = 17'h00400;
            read_en = pick(v.pat, cyc);
            @(negedge clk);
            if (cyc == 1) begin
                check("first_rd", 64'(mem_rd), 64'(1));
                check("first_addr", 64'(mem_addr), 64'(v.base));
                check("busy_on", 64'(busy), 64'(1));
            end
            if (cyc == 2) check("valid_c2", 64'(ref_valid), 64'(0));
            if (cyc == 3) begin
                check("valid_c3", 64'(ref_valid), 64'(1));
                check("first_word", ref_in, v.first);
            end
            if (mem_rd) begin
                if (issue_n == 1) check("addr1", 64'(mem_addr), 64'(v.a1));
                if (issue_n == 2) check("addr2", 64'(mem_addr), 64'(v.a2));
                check("issue_count", 64'(issue_n < N_WORDS), 64'(1));
                check("addr_seq", 64'(mem_addr), 64'(exp_addr(v.base, issue_n)));
                issue_n++;
            end
            if (prev_hold) begin
                check("hold_valid", 64'(ref_valid), 64'(1));
                check("hold_data", ref_in, prev_word);
            end
            if (v.pat == PAT_STALL && cyc == 20) begin
                check("stall_issued", 64'(issue_n), 64'(2));
                check("stall_valid", 64'(ref_valid), 64'(1));
                check("stall_word", ref_in, word_at(v.base));
            end
            if (ref_valid && read_en) begin
                check("word_seq", ref_in, word_at(exp_addr(v.base, xfer_n)));
                xfer_n++;
                last_xfer = cyc;
            end
            check("outstanding", 64'(issue_n - xfer_n <= 2), 64'(1));
            prev_hold = ref_valid && !read_en;
            prev_word = ref_in;
            if (v.abort && xfer_n == 30) begin
                rst     = 1'b1;
                read_en = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("abort_valid", 64'(ref_valid), 64'(0));
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_rd", 64'(mem_rd), 64'(0));
                saw_done = 1'b0;
                repeat (6) begin
                    if (done) saw_done = 1'b1;
                    @(negedge clk);
                end
                check("abort_no_done", 64'(saw_done), 64'(0));
                fin = 1;
            end else if (done) begin
                check("done_count", 64'(xfer_n), 64'(N_WORDS));
                check("done_timing", 64'(cyc), 64'(last_xfer + 1));
                check("busy_off", 64'(busy), 64'(0));
                if (v.pat == PAT_ALWAYS) check("full_rate", 64'(cyc), 64'(72));
                fin = 1;
            end else if (cyc > 3000) begin
                check("timeout", 64'(0), 64'(1));
                fin = 1;
            end
        end
        read_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vec_t rv;
        vecs[0] = '{17'h00000, PAT_ALWAYS, 1'b0, 1'b0, 64'h0706050403020100, 17'h00008, 17'h00010};
        vecs[1] = '{17'h00000, PAT_TOGGLE, 1'b0, 1'b0, 64'h0706050403020100, 17'h00008, 17'h00010};
        vecs[2] = '{17'h00000, PAT_STALL,  1'b0, 1'b0, 64'h0706050403020100, 17'h00008, 17'h00010};
        vecs[3] = '{17'h00000, PAT_ALWAYS, 1'b1, 1'b0, 64'h0706050403020100, 17'h00008, 17'h00010};
        vecs[4] = '{17'h00400, PAT_ALWAYS, 1'b0, 1'b0, 64'h0706050403020100, 17'h00408, 17'h00410};
        vecs[5] = '{17'h00000, PAT_ALWAYS, 1'b0, 1'b1, 64'h0706050403020100, 17'h00008, 17'h00010};
        vecs[6] = '{17'h00160, PAT_TOGGLE, 1'b0, 1'b0, 64'h6766656463626160, 17'h00168, 17'h00170};
        vecs[7] = '{17'h1FFF8, PAT_ALWAYS, 1'b0, 1'b0, 64'hFFFEFDFCFBFAF9F8, 17'h00000, 17'h00008};

        rst      = 1'b1;
        start    = 1'b0;
        read_en  = 1'b0;
        win_base = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_rd", 64'(mem_rd), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_ref_in", ref_in, 64'(0));
        check("rst_ref_valid", 64'(ref_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        for (int i = 0; i < 4; i++) begin
            rv.base  = ADDR_W'($urandom) & ~ADDR_W'(7);
            rv.pat   = PAT_RANDOM;
            rv.poke  = 1'b0;
            rv.abort = 1'b0;
            rv.first = word_at(rv.base);
            rv.a1    = exp_addr(rv.base, 1);
            rv.a2    = exp_addr(rv.base, 2);
            run_vec(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
